// File: rtl/ulpi_reg_pkg.sv
// Shared types and constants for the ULPI PHY register-access arbiter.
// Holds the arbiter state encoding, port widths and well-known ULPI register addresses.
package ulpi_reg_pkg;

    localparam int ULPI_ADDR_W = 6;
    localparam int ULPI_DATA_W = 8;

    localparam logic [ULPI_ADDR_W-1:0] ULPI_REG_VENDOR_ID_LO = 6'h00;
    localparam logic [ULPI_ADDR_W-1:0] ULPI_REG_FUNC_CTRL    = 6'h04;
    localparam logic [ULPI_ADDR_W-1:0] ULPI_REG_IFC_CTRL     = 6'h07;
    localparam logic [ULPI_ADDR_W-1:0] ULPI_REG_OTG_CTRL     = 6'h0A;
    localparam logic [ULPI_ADDR_W-1:0] ULPI_REG_SCRATCH      = 6'h16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ulpi_reg_arbiter_rr.sv
// rr_arbiter: combinational round-robin picker. The winner is the first requester
// after last_i (wrapping); grant_o is one-hot, or all zero when update_i is low.
module rr_arbiter #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    input  logic          update_i,
    output logic [N-1:0]  grant_o
);

    logic found;
    int   idx;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        if (update_i) begin
            for (int k = 1; k <= N; k++) begin
                idx = (int'(last_i) + k) % N;
                if (!found && req_i[idx]) begin
                    grant_o[idx] = 1'b1;
                    found        = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ulpi_reg_arbiter.sv
// Round-robin sharing of the ULPI PHY register port among NREQ requesters.
// Optional acknowledge watchdog is enabled by defining ULPI_ARB_TIMEOUT_EN.
module ulpi_reg_arbiter
    import ulpi_reg_pkg::*;
#(
    parameter int NREQ = 2
`ifdef ULPI_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NREQ-1:0]             REQ_VALID,
    input  logic [NREQ-1:0]             REQ_WRITE,
    input  logic [ULPI_ADDR_W*NREQ-1:0] REQ_ADDR,
    input  logic [ULPI_DATA_W*NREQ-1:0] REQ_WDATA,
    output logic [NREQ-1:0]             REQ_DONE,
    output logic [ULPI_DATA_W-1:0]      REQ_RDATA,
    output logic                        REQ_ERR,
    output logic [ULPI_ADDR_W-1:0]      REG_ADDR,
    output logic [ULPI_DATA_W-1:0]      REG_DATA_WRITE,
    output logic                        REG_WRITE_REQ,
    input  logic                        REG_WRITE_ACK,
    output logic                        REG_READ_REQ,
    input  logic                        REG_READ_ACK,
    input  logic [ULPI_DATA_W-1:0]      REG_DATA_READ
);

    localparam int IW = $clog2(NREQ);

    arb_state_e           state_q, state_d;
    logic [IW-1:0]        last_q, last_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic                 write_q, write_d;
    logic [ULPI_ADDR_W-1:0] addr_q, addr_d;
    logic [ULPI_DATA_W-1:0] wdata_q, wdata_d;
    logic                 wr_req_q, wr_req_d;
    logic                 rd_req_q, rd_req_d;
    logic [NREQ-1:0]      done_q, done_d;
    logic [ULPI_DATA_W-1:0] rdata_q, rdata_d;

    logic [NREQ-1:0]      grant;
    logic [IW-1:0]        grant_idx;
    logic                 ack_any;
    logic                 ack_hit;

`ifdef ULPI_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT - 1);
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    assign REQ_ERR = err_q;
`else
    assign REQ_ERR = 1'b0;
`endif

    assign ack_any = REG_WRITE_ACK | REG_READ_ACK;
    // Only the acknowledge matching the outstanding direction completes a transaction.
    assign ack_hit = write_q ? REG_WRITE_ACK : REG_READ_ACK;

    rr_arbiter #(.N(NREQ)) u_rr (
        .req_i    (REQ_VALID),
        .last_i   (last_q),
        .update_i ((state_q == IDLE) && !ack_any),
        .grant_o  (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) grant_idx = IW'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_req_d = wr_req_q;
        rd_req_d = rd_req_q;
        done_d   = '0;
        rdata_d  = rdata_q;
`ifdef ULPI_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    owner_d  = grant_idx;
                    last_d   = grant_idx;
                    write_d  = REQ_WRITE[grant_idx];
                    addr_d   = REQ_ADDR[grant_idx*ULPI_ADDR_W +: ULPI_ADDR_W];
                    wdata_d  = REQ_WDATA[grant_idx*ULPI_DATA_W +: ULPI_DATA_W];
                    wr_req_d = REQ_WRITE[grant_idx];
                    rd_req_d = !REQ_WRITE[grant_idx];
`ifdef ULPI_ARB_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (ack_hit) begin
                    wr_req_d        = 1'b0;
                    rd_req_d        = 1'b0;
                    done_d[owner_q] = 1'b1;
                    if (!write_q) rdata_d = REG_DATA_READ;
                    state_d         = RELEASE;
                end
`ifdef ULPI_ARB_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_LIM) begin
                    wr_req_d        = 1'b0;
                    rd_req_d        = 1'b0;
                    done_d[owner_q] = 1'b1;
                    err_d           = 1'b1;
                    rdata_d         = '0;
                    state_d         = RELEASE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            RELEASE: begin
                if (!ack_any) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            last_q   <= IW'(NREQ - 1);
            owner_q  <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
            done_q   <= '0;
            rdata_q  <= '0;
`ifdef ULPI_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_req_q <= wr_req_d;
            rd_req_q <= rd_req_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
`ifdef ULPI_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign REQ_DONE       = done_q;
    assign REQ_RDATA      = rdata_q;
    assign REG_ADDR       = addr_q;
    assign REG_DATA_WRITE = wdata_q;
    assign REG_WRITE_REQ  = wr_req_q;
    assign REG_READ_REQ   = rd_req_q;

endmodule

// File: tb/tb_ulpi_reg_arbiter.sv
// Self-checking bench for ulpi_reg_arbiter with NREQ=3: directed scenarios plus a
// randomized phase checked against a round-robin reference model.
module tb_ulpi_reg_arbiter;
    import ulpi_reg_pkg::*;

    localparam int NREQ = 3;
    localparam int TMO  = 8;

    logic                        CLK = 1'b0;
    logic                        RST;
    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0]             req_write;
    logic [ULPI_ADDR_W*NREQ-1:0] req_addr;
    logic [ULPI_DATA_W*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]             REQ_DONE;
    logic [7:0]                  REQ_RDATA;
    logic                        REQ_ERR;
    logic [5:0]                  REG_ADDR;
    logic [7:0]                  REG_DATA_WRITE;
    logic                        REG_WRITE_REQ;
    logic                        REG_WRITE_ACK;
    logic                        REG_READ_REQ;
    logic                        REG_READ_ACK;
    logic [7:0]                  REG_DATA_READ;

    int tests = 0;
    int fails = 0;
    int last_m;
    logic [7:0] rdata_m;

    ulpi_reg_arbiter #(
        .NREQ(NREQ)
`ifdef ULPI_ARB_TIMEOUT_EN
        , .TIMEOUT(TMO)
`endif
    ) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(req_valid), .REQ_WRITE(req_write),
        .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata),
        .REQ_DONE(REQ_DONE), .REQ_RDATA(REQ_RDATA), .REQ_ERR(REQ_ERR),
        .REG_ADDR(REG_ADDR), .REG_DATA_WRITE(REG_DATA_WRITE),
        .REG_WRITE_REQ(REG_WRITE_REQ), .REG_WRITE_ACK(REG_WRITE_ACK),
        .REG_READ_REQ(REG_READ_REQ), .REG_READ_ACK(REG_READ_ACK),
        .REG_DATA_READ(REG_DATA_READ)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input bit wr, input logic [5:0] a, input logic [7:0] d);
        req_valid[i]         = 1'b1;
        req_write[i]         = wr;
        req_addr[6*i +: 6]   = a;
        req_wdata[8*i +: 8]  = d;
    endtask

    // Reference winner: first valid requester after the last one granted, wrapping.
    function automatic int pick();
        for (int k = 1; k <= NREQ; k++) begin
            if (req_valid[(last_m + k) % NREQ]) return (last_m + k) % NREQ;
        end
        return -1;
    endfunction

    // Wait for the grant, check operands, acknowledge after dly cycles, hold ACK for hold cycles.
    task automatic run_txn(input int dly, input int hold, input logic [7:0] rdv,
                           input bit keep, input int exp_lat);
        int  w;
        int  n;
        bit  wr;
        w = pick();
        n = 0;
        do begin
            tick();
            n++;
            chk("done_idle", 32'(REQ_DONE), 32'd0);
            chk("one_req", 32'(REG_WRITE_REQ & REG_READ_REQ), 32'd0);
        end while (!(REG_WRITE_REQ || REG_READ_REQ) && n < 20);
        chk("grant_lat", 32'(n), 32'(exp_lat));
        if (w < 0 || n >= 20) return;
        wr = req_write[w];
        chk("req_dir", 32'({REG_WRITE_REQ, REG_READ_REQ}), wr ? 32'd2 : 32'd1);
        chk("reg_addr", 32'(REG_ADDR), 32'(req_addr[6*w +: 6]));
        chk("reg_wdata", 32'(REG_DATA_WRITE), 32'(req_wdata[8*w +: 8]));
        for (int i = 0; i < dly; i++) begin
            if (i == 0 && dly >= 2) begin
                if (wr) REG_READ_ACK = 1'b1; else REG_WRITE_ACK = 1'b1;
            end else begin
                REG_READ_ACK  = 1'b0;
                REG_WRITE_ACK = 1'b0;
            end
            tick();
            chk("req_hold", 32'({REG_WRITE_REQ, REG_READ_REQ}), wr ? 32'd2 : 32'd1);
            chk("done_early", 32'(REQ_DONE), 32'd0);
        end
        REG_READ_ACK  = !wr;
        REG_WRITE_ACK = wr;
        REG_DATA_READ = wr ? 8'($urandom) : rdv;
        tick();
        if (!wr) rdata_m = rdv;
        last_m = w;
        chk("done_pulse", 32'(REQ_DONE), 32'(1) << w);
        chk("req_clear", 32'({REG_WRITE_REQ, REG_READ_REQ}), 32'd0);
        chk("rdata", 32'(REQ_RDATA), 32'(rdata_m));
        chk("err_low", 32'(REQ_ERR), 32'd0);
        $display("[TB] txn req=%0d %s addr=%02h wdata=%02h rdata=%02h", w, wr ? "WR" : "RD",
                 REG_ADDR, REG_DATA_WRITE, REQ_RDATA);
        if (!keep) req_valid[w] = 1'b0;
        for (int i = 1; i < hold; i++) begin
            tick();
            chk("stale_nogrant", 32'({REG_WRITE_REQ, REG_READ_REQ}), 32'd0);
            chk("done_once", 32'(REQ_DONE), 32'd0);
        end
        REG_READ_ACK  = 1'b0;
        REG_WRITE_ACK = 1'b0;
    endtask

    initial begin
        int n;
        RST = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        REG_WRITE_ACK = 1'b0; REG_READ_ACK = 1'b0; REG_DATA_READ = 8'h00;
        last_m = NREQ - 1;
        rdata_m = 8'h00;
        repeat (3) tick();
        RST = 1'b0;
        chk("rst_done", 32'(REQ_DONE), 32'd0);
        chk("rst_rdata", 32'(REQ_RDATA), 32'd0);
        chk("rst_err", 32'(REQ_ERR), 32'd0);
        chk("rst_addr", 32'(REG_ADDR), 32'd0);
        chk("rst_wdata", 32'(REG_DATA_WRITE), 32'd0);
        chk("rst_reqs", 32'({REG_WRITE_REQ, REG_READ_REQ}), 32'd0);

        // Single write, then a read from requester 1.
        set_req(0, 1'b1, ULPI_REG_FUNC_CTRL, 8'h48);
        run_txn(1, 1, 8'h00, 1'b0, 1);
        set_req(1, 1'b0, ULPI_REG_VENDOR_ID_LO, 8'h00);
        run_txn(0, 1, 8'h24, 1'b0, 2);

        // Stale acknowledge held after completion while requester 0 stays valid.
        set_req(0, 1'b0, ULPI_REG_SCRATCH, 8'h00);
        run_txn(0, 5, 8'h3C, 1'b1, 2);
        run_txn(0, 1, 8'hC3, 1'b0, 2);

        // Fairness with all requesters continuously valid.
        set_req(0, 1'b1, ULPI_REG_IFC_CTRL, 8'h11);
        set_req(1, 1'b0, ULPI_REG_OTG_CTRL, 8'h00);
        set_req(2, 1'b1, ULPI_REG_SCRATCH, 8'h33);
        for (int t = 0; t < 5; t++) run_txn(0, 1, 8'($urandom), 1'b1, 2);
        req_valid = '0;
        req_valid[(last_m + 1) % NREQ] = 1'b1;
        run_txn(0, 1, 8'($urandom), 1'b0, 2);

        // Randomized traffic.
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && ($urandom % 2 == 1))
                    set_req(i, 1'($urandom), 6'($urandom), 8'($urandom));
            end
            if (req_valid == '0)
                set_req(int'($urandom % NREQ), 1'($urandom), 6'($urandom), 8'($urandom));
            run_txn(int'($urandom % 4), 1 + int'($urandom % 3), 8'($urandom), 1'b0, 2);
        end
        while (req_valid != '0) run_txn(1, 1, 8'($urandom), 1'b0, 2);
        repeat (3) tick();

        // Unanswered read: watchdog completion or indefinite wait.
        set_req(2, 1'b0, ULPI_REG_OTG_CTRL, 8'h00);
`ifdef ULPI_ARB_TIMEOUT_EN
        n = 0;
        do begin tick(); n++; end while (!REG_READ_REQ && n < 20);
        chk("tmo_grant", 32'(n), 32'd1);
        n = 0;
        do begin tick(); n++; end while (REQ_DONE == '0 && n < 50);
        chk("tmo_cycles", 32'(n), 32'(TMO));
        chk("tmo_done", 32'(REQ_DONE), 32'd4);
        chk("tmo_err", 32'(REQ_ERR), 32'd1);
        chk("tmo_rdata", 32'(REQ_RDATA), 32'd0);
        chk("tmo_req", 32'(REG_READ_REQ), 32'd0);
        $display("[TB] txn req=2 RD timeout err=%0d", REQ_ERR);
        rdata_m = 8'h00;
        last_m = 2;
        req_valid[2] = 1'b0;
`else
        run_txn(30, 1, 8'h5A, 1'b0, 1);
`endif
        repeat (3) tick();

        // Reset while a read is outstanding.
        set_req(1, 1'b0, ULPI_REG_FUNC_CTRL, 8'h00);
        n = 0;
        do begin tick(); n++; end while (!REG_READ_REQ && n < 20);
        chk("rstmid_grant", 32'(n), 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("rstmid_req", 32'({REG_WRITE_REQ, REG_READ_REQ}), 32'd0);
        chk("rstmid_done", 32'(REQ_DONE), 32'd0);
        chk("rstmid_rdata", 32'(REQ_RDATA), 32'd0);
        $display("[TB] txn req=1 RD aborted by reset");
        last_m = NREQ - 1;
        rdata_m = 8'h00;
        set_req(0, 1'b1, ULPI_REG_SCRATCH, 8'hA5);
        run_txn(0, 1, 8'h00, 1'b0, 1);
        run_txn(2, 1, 8'h6E, 1'b0, 2);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ulpi_reg_arbiter.md
# ulpi_reg_arbiter

Shares the single ULPI PHY register-access port (address, write data, write/read request and acknowledge) between NREQ independent requesters, e.g. the PHY init sequencer, the host CSR bridge and the register-dump logic. It grants the port round-robin, runs one complete request/acknowledge transaction at a time, and returns read data and a completion strobe to the granted requester. It sits between the requesters and the ULPI link-layer register engine.

## Interface
- NREQ, 2: number of requesters, 2..8.
- TIMEOUT, 255: acknowledge watchdog limit in CLK cycles, 1..65535. Used only when ULPI_ARB_TIMEOUT_EN is defined.

- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  synchronous reset, active-high.
- REQ_VALID  in  NREQ  per-requester access request; held high until that requester's REQ_DONE bit pulses.
- REQ_WRITE  in  NREQ  per-requester direction; 1 = write, 0 = read.
- REQ_ADDR  in  6*NREQ  per-requester register address; requester i uses bits [6i+5:6i].
- REQ_WDATA  in  8*NREQ  per-requester write data; requester i uses bits [8i+7:8i].
- REQ_DONE  out  NREQ  one-cycle completion pulse to the granted requester.
- REQ_RDATA  out  8  read data; valid in the REQ_DONE cycle and held until the next completion.
- REQ_ERR  out  1  high in the REQ_DONE cycle when the transaction timed out.
- REG_ADDR  out  6  register address to the PHY engine.
- REG_DATA_WRITE  out  8  write data to the PHY engine.
- REG_WRITE_REQ  out  1  write request.
- REG_WRITE_ACK  in  1  write acknowledge.
- REG_READ_REQ  out  1  read request.
- REG_READ_ACK  in  1  read acknowledge.
- REG_DATA_READ  in  8  read data; valid while REG_READ_ACK is high.

## Operation
- States: IDLE, ISSUE, RELEASE.
- IDLE:
  - When any REQ_VALID bit is high and both ACK inputs are low, choose the winner i, latch its address, data and direction into REG_*, assert the matching *_REQ, and go to ISSUE.
  - While either ACK is high, no grant is made. This drains any stale acknowledge.
- Arbitration: the winner is the lowest index greater than the last granted index whose REQ_VALID bit is high, wrapping from NREQ-1 to 0. After reset the last-granted pointer is NREQ-1, so requester 0 wins first.
- ISSUE: hold *_REQ and the operands stable until the matching ACK is seen high. On that edge:
  - clear *_REQ;
  - pulse REQ_DONE[i];
  - for a read, capture REG_DATA_READ into REQ_RDATA;
  - go to RELEASE.
- RELEASE: wait until both ACK inputs are low, then go to IDLE.
- An ACK of the wrong type in ISSUE (e.g. REG_READ_ACK during a write) is ignored.
- If REQ_VALID[i] drops while in ISSUE, the transaction still completes and REQ_DONE[i] still pulses.
- A requester may raise REQ_VALID again in the cycle after its REQ_DONE. It then competes normally, and another valid requester wins first.
- Reset values:
  - all REQ_* outputs and *_REQ outputs 0;
  - REG_ADDR and REG_DATA_WRITE 0;
  - REQ_RDATA 8'h00;
  - state IDLE.
- Reset during ISSUE drops *_REQ on the reset edge. No REQ_DONE is produced for the aborted transaction.

## Timing
- Grant: REQ_VALID high at edge T (IDLE, ACKs low) gives *_REQ high after edge T.
- Completion: ACK high at edge A gives *_REQ low, REQ_DONE high and REQ_RDATA updated, all after edge A.
- Minimum cycle time per transaction is 3 cycles: IDLE, ISSUE and one RELEASE cycle, with a 1-cycle ACK that drops immediately.
- Back-to-back grants never overlap. At most one *_REQ is high at any time.
- REG_ADDR and REG_DATA_WRITE are registered and change only on a grant edge.

## Configuration
- ULPI_ARB_TIMEOUT_EN defined:
  - a 16-bit counter clears on entry to ISSUE and increments each ISSUE cycle;
  - when it reaches TIMEOUT with no ACK, clear *_REQ, pulse REQ_DONE[i] with REQ_ERR=1 and REQ_RDATA=8'h00, and go to RELEASE.
  - An ACK arriving on the same edge the count hits TIMEOUT wins: normal completion, REQ_ERR=0.
- ULPI_ARB_TIMEOUT_EN undefined:
  - no counter; ISSUE waits indefinitely;
  - REQ_ERR is tied 0.

## Structure
- Package ulpi_reg_pkg holds:
  - the state enum (IDLE/ISSUE/RELEASE);
  - ULPI_ADDR_W=6 and ULPI_DATA_W=8;
  - named register addresses, e.g. ULPI_REG_FUNC_CTRL=6'h04.
- Sub-module rr_arbiter (parameter N): inputs request vector, last-grant index and an update strobe; output one-hot grant. It is purely round-robin and reusable.

## Test plan
- Single write: requester 0 writes 8'h48 to 6'h04, ACK returns 2 cycles after REG_WRITE_REQ rises -> REG_ADDR=6'h04, REG_DATA_WRITE=8'h48, REQ_DONE[0] pulses once, REG_WRITE_REQ clears on the ACK edge.
- Read data: requester 1 reads 6'h00, PHY returns 8'h24 with REG_READ_ACK -> REQ_RDATA=8'h24 in the REQ_DONE[1] cycle, REQ_ERR=0.
- Fairness: NREQ=3, all requesters continuously valid -> grant order 0,1,2,0,1,2; only one *_REQ is ever high.
- Stale ACK: ACK held high for 4 cycles after completion while requester 0 is valid -> no grant until ACK is low, then REG_*_REQ rises the cycle after.
- Timeout (macro on, TIMEOUT=8): PHY never ACKs -> REQ_DONE with REQ_ERR=1 and REQ_RDATA=8'h00 exactly 8 ISSUE cycles after REQ rises. With the macro off, REQ stays high indefinitely.
- Reset mid-ISSUE: RST is asserted for 1 cycle while REG_READ_REQ is high -> REQ drops, no REQ_DONE, requester 0 wins the next grant.
